// File: rtl/mc_mem_responder_pkg.sv
// Shared constants for the multicycle memory responder.
// State encodings, wait counter width and word-index width helper.
package mem_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam int WAIT_CNT_W = 4;

   // index width of the default 256-word array
   localparam int IDX_W_DEF = 8;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/mc_mem_responder_if.sv
// Processor <-> memory responder request/response bundle.
// master = processor side, slave = responder side.
interface mc_mem_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              memread;
   logic              memwrite;
   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ready;
   logic              err;
   logic              busy;

   modport master (
      output memread, memwrite, adr, wdata,
      input  rdata, ready, err, busy
   );

   modport slave (
      input  memread, memwrite, adr, wdata,
      output rdata, ready, err, busy
   );

endinterface

// File: rtl/mc_mem_responder_ram.sv
// Single-port synchronous word array with registered read data.
// Read returns the contents before a same-cycle write.
module mem_word_ram #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32,
   parameter int IW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IW-1:0]     idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
      rdata_q <= mem_q[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_mem_responder.sv
// Wait-state memory responder for the multicycle core's memory port.
// Define MEM_ALIGN_CHECK_EN to flag misaligned addresses as errors.
module mc_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic clk,
   input logic reset,
   mc_mem_responder_if.slave bus
);

   localparam int IW = idx_w(DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LD =
      WAIT_CNT_W'(WAIT_CYCLES);
   localparam logic [1:0] FIRST_ST =
      (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;

   logic [1:0]            state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic [ADDR_W-1:0]     adr_q, adr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;

   logic              req;
   logic              resp;
   logic              bad;
   logic              ready;
   logic              ram_we;
   logic [IW-1:0]     ram_idx;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] rdata_o;

   assign req  = bus.memread | bus.memwrite;
   assign resp = (state_q == ST_RESP);

`ifdef MEM_ALIGN_CHECK_EN
   assign bad = (adr_q[ADDR_W-1:IW+2] != '0)
              | (rd_q & wr_q)
              | (adr_q[1:0] != 2'b00);
`else
   logic unused_lsb;
   assign unused_lsb = ^adr_q[1:0];
   assign bad = (adr_q[ADDR_W-1:IW+2] != '0)
              | (rd_q & wr_q);
`endif

   // look up the incoming word while idle so zero-wait reads hit
   assign ram_idx = (state_q == ST_IDLE) ? bus.adr[IW+1:2]
                                         : adr_q[IW+1:2];

   assign ready  = resp & ~reset;
   assign ram_we = ready & wr_q & ~bad;

   assign bus.ready = ready;
   assign bus.err   = ready & bad;
   assign bus.busy  = (state_q != ST_IDLE);
   assign bus.rdata = rdata_o;

   always_comb begin
      rdata_d = rdata_q;
      rdata_o = rdata_q;
      if (ready) begin
         if (bad) begin
            rdata_o = '0;
         end else if (rd_q) begin
            rdata_o = ram_rdata;
         end
         if (rd_q & ~wr_q) begin
            rdata_d = rdata_o;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      unique case (1'b1)
         (state_q == ST_IDLE): begin
            if (req) begin
               rd_d    = bus.memread;
               wr_d    = bus.memwrite;
               adr_d   = bus.adr;
               wdata_d = bus.wdata;
               cnt_d   = WAIT_LD;
               state_d = FIRST_ST;
            end
         end
         (state_q == ST_WAIT): begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == WAIT_CNT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         (state_q == ST_RESP): begin
            state_d = ST_HOLD;
         end
         (state_q == ST_HOLD): begin
            if (!req) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         adr_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   mem_word_ram #(
      .DEPTH  (DEPTH_WORDS),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .idx_i   (ram_idx),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_mc_mem_responder.sv
// Scoreboard bench for mc_mem_responder with a word-level memory model.
// Honours MEM_ALIGN_CHECK_EN in its expectations.
module tb_mc_mem_responder;

   localparam int W     = 2;
   localparam int DEPTH = 256;

   typedef struct {
      bit          err;
      bit          chk;
      logic [31:0] rdata;
      int          cyc;
      int          id;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ready_cnt = 0;
   int   txn_id = 0;

   exp_t        sb[$];
   logic [31:0] mem_m [int];

   mc_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) mif ();

   mc_mem_responder #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES (W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   // monitor: every ready pulse pops and checks one expectation
   always @(negedge clk) begin
      exp_t e;
      if (mif.ready === 1'b1) begin
         ready_cnt++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ready: actual=1 required=0 cyc=%0d",
                     cyc);
         end else begin
            e = sb.pop_front();
            chk($sformatf("latency#%0d", e.id), cyc, e.cyc);
            chk($sformatf("err#%0d", e.id), {31'd0, mif.err},
                {31'd0, e.err});
            if (e.chk) begin
               chk($sformatf("rdata#%0d", e.id), mif.rdata, e.rdata);
            end
         end
      end else if (!reset) begin
         chk("err_without_ready", {31'd0, mif.err}, 32'd0);
      end
   end

   task automatic wait_idle();
      @(negedge clk);
      for (int i = 0; i < 50; i++) begin
         if (mif.busy === 1'b0) return;
         @(negedge clk);
      end
      chk("idle_timeout", {31'd0, mif.busy}, 32'd0);
   endtask

   task automatic issue(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int hold);
      exp_t e;
      bit   bad;
      bit   seen;
      int   w;
      wait_idle();
      w   = int'(a >> 2);
      bad = (w >= DEPTH) || (rd && wr);
`ifdef MEM_ALIGN_CHECK_EN
      if (a[1:0] != 2'b00) bad = 1'b1;
`endif
      e.err   = bad;
      e.cyc   = cyc + W + 1;
      e.id    = txn_id++;
      e.chk   = bad;
      e.rdata = 32'd0;
      if (!bad && rd && mem_m.exists(w)) begin
         e.chk   = 1'b1;
         e.rdata = mem_m[w];
      end
      if (!bad && wr) mem_m[w] = d;
      mif.memread  = rd;
      mif.memwrite = wr;
      mif.adr      = a;
      mif.wdata    = d;
      sb.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mif.ready === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         chk("ready_timeout", 32'd0, 32'd1);
         void'(sb.pop_back());
      end
      // garbage on the bus after sampling must not matter
      mif.adr   = $urandom;
      mif.wdata = $urandom;
      repeat (1 + hold) @(negedge clk);
      chk("busy_in_hold", {31'd0, mif.busy}, 32'd1);
      mif.memread  = 1'b0;
      mif.memwrite = 1'b0;
      @(negedge clk);
      chk("busy_after_drop", {31'd0, mif.busy}, 32'd0);
   endtask

   initial begin
      int          rc0;
      int          k;
      bit          rd;
      bit          wr;
      logic [31:0] a;
      mif.memread  = 1'b0;
      mif.memwrite = 1'b0;
      mif.adr      = '0;
      mif.wdata    = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, mif.ready}, 32'd0);
      chk("rst_err", {31'd0, mif.err}, 32'd0);
      chk("rst_busy", {31'd0, mif.busy}, 32'd0);
      chk("rst_rdata", mif.rdata, 32'd0);
      reset = 1'b0;

      issue(0, 1, 32'h10, 32'hDEADBEEF, 0);
      issue(1, 0, 32'h10, 32'h0, 0);
      repeat (5) @(negedge clk);
      chk("rdata_held", mif.rdata, 32'hDEADBEEF);

      issue(0, 1, 32'h0, 32'hA5A50000, 1);
      issue(1, 0, 32'h400, 32'h0, 0);
      issue(1, 0, 32'h0, 32'h0, 0);

      issue(0, 1, 32'h20, 32'h00002020, 0);
      issue(1, 1, 32'h20, 32'hFFFFFFFF, 2);
      issue(1, 0, 32'h20, 32'h0, 0);

      issue(0, 1, 32'h13, 32'h12345678, 0);
      issue(1, 0, 32'h10, 32'h0, 0);

      issue(0, 1, 32'h30, 32'h30303030, 0);
      wait_idle();
      mif.memwrite = 1'b1;
      mif.adr      = 32'h30;
      mif.wdata    = 32'hBADBAD00;
      @(negedge clk);
      chk("busy_in_wait", {31'd0, mif.busy}, 32'd1);
      reset        = 1'b1;
      mif.memwrite = 1'b0;
      @(negedge clk);
      chk("busy_after_reset", {31'd0, mif.busy}, 32'd0);
      reset = 1'b0;
      issue(1, 0, 32'h30, 32'h0, 0);

      rc0 = ready_cnt;
      issue(1, 0, 32'h10, 32'h0, 9);
      chk("single_ready_pulse", ready_cnt - rc0, 32'd1);

      for (int n = 0; n < 80; n++) begin
         k  = $urandom_range(0, 9);
         rd = (k < 4) || (k == 9);
         wr = (k >= 4);
         k  = $urandom_range(0, 9);
         if (k < 8) begin
            a = 32'($urandom_range(0, 15)) << 2;
         end else if (k == 8) begin
            a = $urandom | 32'h400;
         end else begin
            a = (32'($urandom_range(0, 15)) << 2)
              + 32'($urandom_range(1, 3));
         end
         issue(rd, wr, a, $urandom, $urandom_range(0, 3));
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
